seg_595_dynamic: RTL and testbench

Parametrised successor to the static 74HC595 segment driver. It multiplexes `DIGITS` common-anode 7-segment digits: one digit is refreshed per scan period. For each digit it serialises a `{seg, sel}` word into the daisy-chained 595s and then pulses the storage latch. It sits between the application's display data (hex nibbles, decimal points, enable) and the board-level `ds`/`shcp`/`stcp`/`oe` pins.

---
 rtl/seg_pkg.sv | 31 +++
 rtl/seg_hex_decode.sv | 29 ++
 rtl/seg_595_dynamic.sv | 215 +++++++++++++++++++++
 tb/tb_seg_595_dynamic.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the multiplexed 74HC595 seven-segment driver:
//   - SEG_HEX_TABLE : active-low {dp,g,f,e,d,c,b,a} codes for hex 0..F
//                     (dp bit is 1 = off; the decoder overrides it)
//   - SEG_BLANK     : all segments off
//   - seg_state_e   : scan/shift FSM states
//   - seg_word_width: length of the {seg, sel} shift word for a digit count
// -----------------------------------------------------------------------------
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [7:0] SEG_HEX_TABLE [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_LATCH = 2'd3
    } seg_state_e;

    // Eight segment bits followed by one select bit per digit.
    function automatic int seg_word_width(input int digits);
        return 32'sd8 + digits;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// -----------------------------------------------------------------------------
// seg_hex_decode
// Combinational nibble -> active-low seven-segment decoder.
// Ports:
//   nibble  in  4 : hex value to display
//   point   in  1 : decimal point, 1 = lit
//   blank   in  1 : 1 = all segments off (leading-zero suppression)
//   seg     out 8 : {dp,g,f,e,d,c,b,a}, active low
// -----------------------------------------------------------------------------
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       point,
    input  logic       blank,
    output logic [7:0] seg
);

    // Table lookup with the dp bit replaced by the inverted point input.
    always_comb begin
        seg = SEG_BLANK;
        if (blank) begin
            seg = SEG_BLANK;
        end else begin
            seg = {~point, SEG_HEX_TABLE[nibble][6:0]};
        end
    end

endmodule

// File: rtl/seg_595_dynamic.sv
// -----------------------------------------------------------------------------
// seg_595_dynamic
// Multiplexes DIGITS common-anode digits through a daisy-chained 74HC595 pair.
// Every SCAN_CNT clocks one digit's {seg, sel} word is shifted out MSB first
// (4 clocks per bit) and then latched with a one-cycle stcp pulse.
// Parameters:
//   DIGITS   : number of digits / width of sel (1..8)
//   SCAN_CNT : clocks per digit slot, >= 4*(8+DIGITS)+4
// Ports:
//   sys_clk    in  1          : clock
//   sys_rst_n  in  1          : async active-low reset
//   data       in  4*DIGITS   : hex nibble per digit, data[3:0] = digit 0
//   point      in  DIGITS     : decimal point per digit, 1 = lit
//   seg_en     in  1          : 1 = display on
//   ds         out 1          : 595 serial data
//   shcp       out 1          : 595 shift clock
//   stcp       out 1          : 595 storage clock
//   oe         out 1          : 595 output enable, active low
// Build option:
//   SEG_LZ_BLANK_EN : when defined, leading zero digits (except digit 0) are
//                     blanked unless a decimal point at or above them is lit.
// -----------------------------------------------------------------------------
module seg_595_dynamic
    import seg_pkg::*;
#(
    parameter int DIGITS   = 6,
    parameter int SCAN_CNT = 50_000
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     point,
    input  logic                  seg_en,
    output logic                  ds,
    output logic                  shcp,
    output logic                  stcp,
    output logic                  oe
);

    localparam int WORD_W = seg_word_width(DIGITS);
    localparam int SH_W   = WORD_W - 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SCAN_W = $clog2(SCAN_CNT);
    localparam int BIT_W  = $clog2(WORD_W);

    logic [SCAN_W-1:0] scan_cnt_r;
    logic              tick_s;
    seg_state_e        state_r, state_nxt_s;
    logic [1:0]        cnt4_r, cnt4_nxt_s;
    logic [BIT_W-1:0]  bit_cnt_r, bit_cnt_nxt_s;
    logic [SH_W-1:0]   shift_r, shift_nxt_s;
    logic [IDX_W-1:0]  digit_idx_r, digit_idx_nxt_s;
    logic              ds_r, ds_nxt_s;
    logic              shcp_r, shcp_nxt_s;
    logic              stcp_r, stcp_nxt_s;
    logic              oe_r;

    logic [DIGITS-1:0] sel_s;
    logic [DIGITS-1:0] blank_vec_s;
    logic [3:0]        nibble_s;
    logic              point_bit_s;
    logic              blank_s;
    logic [7:0]        seg_s;
    logic [WORD_W-1:0] word_s;

    assign tick_s = (scan_cnt_r == SCAN_W'(SCAN_CNT - 1));
    assign word_s = {seg_s, sel_s};

    // Free-running slot counter; tick_s marks the last cycle of each slot.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            scan_cnt_r <= '0;
        end else if (tick_s) begin
            scan_cnt_r <= '0;
        end else begin
            scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
        end
    end

`ifdef SEG_LZ_BLANK_EN
    // Walk from the top digit down; a digit stays blank while every nibble
    // and point from the top through it is zero. Digit 0 always shows.
    always_comb begin : lz_blank
        logic run_v;
        run_v       = 1'b1;
        blank_vec_s = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run_v          = run_v & (data[4*i +: 4] == 4'h0) & ~point[i];
            blank_vec_s[i] = (i > 0) ? run_v : 1'b0;
        end
    end
`else
    // Leading zeros are displayed.
    always_comb begin
        blank_vec_s = '0;
    end
`endif

    // One-hot select and AND-OR mux of the current digit's inputs.
    always_comb begin
        sel_s       = '0;
        nibble_s    = 4'h0;
        point_bit_s = 1'b0;
        blank_s     = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            sel_s[i]    = (digit_idx_r == IDX_W'(i));
            nibble_s    = nibble_s | (data[4*i +: 4] & {4{sel_s[i]}});
            point_bit_s = point_bit_s | (point[i] & sel_s[i]);
            blank_s     = blank_s | (blank_vec_s[i] & sel_s[i]);
        end
    end

    seg_hex_decode u_decode (
        .nibble (nibble_s),
        .point  (point_bit_s),
        .blank  (blank_s),
        .seg    (seg_s)
    );

    // Next-state and next-output logic. Outputs are computed one cycle ahead
    // so ds/shcp/stcp come straight from flops.
    always_comb begin
        state_nxt_s     = state_r;
        cnt4_nxt_s      = cnt4_r;
        bit_cnt_nxt_s   = bit_cnt_r;
        shift_nxt_s     = shift_r;
        digit_idx_nxt_s = digit_idx_r;
        ds_nxt_s        = ds_r;
        shcp_nxt_s      = 1'b0;
        stcp_nxt_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (tick_s) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // MSB goes straight to ds; the rest waits in shift_r.
                state_nxt_s   = ST_SHIFT;
                ds_nxt_s      = word_s[WORD_W-1];
                shift_nxt_s   = word_s[SH_W-1:0];
                cnt4_nxt_s    = 2'd0;
                bit_cnt_nxt_s = '0;
                if (digit_idx_r == IDX_W'(DIGITS - 1)) begin
                    digit_idx_nxt_s = '0;
                end else begin
                    digit_idx_nxt_s = digit_idx_r + IDX_W'(1);
                end
            end
            ST_SHIFT: begin
                if (cnt4_r == 2'd3) begin
                    cnt4_nxt_s = 2'd0;
                    if (bit_cnt_r == BIT_W'(WORD_W - 1)) begin
                        state_nxt_s = ST_LATCH;
                        stcp_nxt_s  = 1'b1;
                    end else begin
                        bit_cnt_nxt_s = bit_cnt_r + BIT_W'(1);
                        ds_nxt_s      = shift_r[SH_W-1];
                        shift_nxt_s   = {shift_r[SH_W-2:0], 1'b0};
                    end
                end else begin
                    cnt4_nxt_s = cnt4_r + 2'd1;
                    // High during cnt4 = 2 and 3.
                    shcp_nxt_s = (cnt4_r == 2'd1) || (cnt4_r == 2'd2);
                end
            end
            ST_LATCH: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM, shifter and pin registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r     <= ST_IDLE;
            cnt4_r      <= 2'd0;
            bit_cnt_r   <= '0;
            shift_r     <= '0;
            digit_idx_r <= '0;
            ds_r        <= 1'b0;
            shcp_r      <= 1'b0;
            stcp_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt4_r      <= cnt4_nxt_s;
            bit_cnt_r   <= bit_cnt_nxt_s;
            shift_r     <= shift_nxt_s;
            digit_idx_r <= digit_idx_nxt_s;
            ds_r        <= ds_nxt_s;
            shcp_r      <= shcp_nxt_s;
            stcp_r      <= stcp_nxt_s;
        end
    end

    // Output enable follows seg_en with one cycle of latency, independent of scanning.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            oe_r <= 1'b1;
        end else begin
            oe_r <= ~seg_en;
        end
    end

    assign ds   = ds_r;
    assign shcp = shcp_r;
    assign stcp = stcp_r;
    assign oe   = oe_r;

endmodule

// File: tb/tb_seg_595_dynamic.sv
// -----------------------------------------------------------------------------
// tb_seg_595_dynamic
// Directed bench for seg_595_dynamic (DIGITS=6, SCAN_CNT=64). A monitor
// reassembles each shifted frame from ds on shcp rising edges and records the
// cycle of the stcp pulse; the main sequence compares frames against a table.
// -----------------------------------------------------------------------------
module tb_seg_595_dynamic;

    localparam int DIGITS     = 6;
    localparam int SCAN_CNT   = 64;
    localparam int WORD_W     = 8 + DIGITS;
    // LOAD happens SCAN_CNT clocks after release; stcp follows 1+4*WORD_W later.
    localparam int FIRST_STCP = SCAN_CNT + 1 + 4 * WORD_W;

    logic                sys_clk = 1'b0;
    logic                sys_rst_n = 1'b1;
    logic [4*DIGITS-1:0] data = '0;
    logic [DIGITS-1:0]   point = '0;
    logic                seg_en = 1'b1;
    logic                ds, shcp, stcp, oe;

    int checks = 0;
    int failures = 0;
    int cyc;
    int frame_k;

    typedef struct {
        logic [WORD_W-1:0] word;
        int                nbits;
        int                cyc;
    } frame_t;

    typedef struct {
        logic [23:0] data;
        logic [5:0]  point;
        logic [7:0]  seg_plain;
        logic [7:0]  seg_lz;
    } vec_t;

    frame_t frames[$];
    logic [WORD_W-1:0] mon_sh;
    int mon_bits;
    vec_t vecs[21];

    seg_595_dynamic #(.DIGITS(DIGITS), .SCAN_CNT(SCAN_CNT)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .data      (data),
        .point     (point),
        .seg_en    (seg_en),
        .ds        (ds),
        .shcp      (shcp),
        .stcp      (stcp),
        .oe        (oe)
    );

    always #5 sys_clk = ~sys_clk;

    // Clocks since reset release.
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) cyc <= 0;
        else            cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame monitor, sampled on the falling edge.
    initial begin : monitor
        logic   shcp_q, stcp_q;
        frame_t f;
        shcp_q   = 1'b0;
        stcp_q   = 1'b0;
        mon_sh   = '0;
        mon_bits = 0;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst_n) begin
                mon_sh   = '0;
                mon_bits = 0;
                shcp_q   = 1'b0;
                stcp_q   = 1'b0;
            end else begin
                if (stcp_q) check("stcp_width", {31'd0, stcp}, 32'd0);
                if (shcp && !shcp_q) begin
                    mon_sh   = {mon_sh[WORD_W-2:0], ds};
                    mon_bits = mon_bits + 1;
                end
                if (stcp && !stcp_q) begin
                    f.word  = mon_sh;
                    f.nbits = mon_bits;
                    f.cyc   = cyc;
                    frames.push_back(f);
                    mon_bits = 0;
                end
                shcp_q = shcp;
                stcp_q = stcp;
            end
        end
    end

    task automatic wait_frame(output frame_t f, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge sys_clk);
            #1;
            if (frames.size() > 0) begin
                f  = frames.pop_front();
                ok = 1'b1;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL frame_timeout: got no stcp frame expected one within 300 cycles (frame %0d)", frame_k);
        end
    endtask

    // Next frame must carry exp_seg for digit frame_k % DIGITS at its scheduled cycle.
    task automatic check_frame(input string name, input logic [7:0] exp_seg);
        frame_t            f;
        bit                ok;
        logic [DIGITS-1:0] one;
        logic [DIGITS-1:0] sel;
        one = 6'd1;
        sel = one << (frame_k % DIGITS);
        wait_frame(f, ok);
        if (ok) begin
            check({name, "_word"}, {18'd0, f.word}, {18'd0, exp_seg, sel});
            check({name, "_bits"}, f.nbits, WORD_W);
            check({name, "_cyc"}, f.cyc, FIRST_STCP + SCAN_CNT * frame_k);
        end
        frame_k++;
    endtask

    initial begin : main
        bit hit;
        // data, point, seg without blanking, seg with leading-zero blanking
        vecs[0]  = '{24'h123456, 6'b000000, 8'h92, 8'h92}; // d1 '5'
        vecs[1]  = '{24'h123456, 6'b000100, 8'h19, 8'h19}; // d2 '4' + dp
        vecs[2]  = '{24'h123456, 6'b000100, 8'hB0, 8'hB0}; // d3 '3'
        vecs[3]  = '{24'hFEDCBA, 6'b010000, 8'h06, 8'h06}; // d4 'E' + dp
        vecs[4]  = '{24'hFEDCBA, 6'b000000, 8'h8E, 8'h8E}; // d5 'F'
        vecs[5]  = '{24'hFEDCBA, 6'b000001, 8'h08, 8'h08}; // d0 'A' + dp, wrap
        vecs[6]  = '{24'hFEDCBA, 6'b000000, 8'h83, 8'h83}; // d1 'b'
        vecs[7]  = '{24'hFEDCBA, 6'b000000, 8'hC6, 8'hC6}; // d2 'C'
        vecs[8]  = '{24'hFEDCBA, 6'b000000, 8'hA1, 8'hA1}; // d3 'd'
        vecs[9]  = '{24'h000012, 6'b000000, 8'hC0, 8'hFF}; // d4 leading zero
        vecs[10] = '{24'h000012, 6'b000000, 8'hC0, 8'hFF}; // d5 leading zero
        vecs[11] = '{24'h000012, 6'b000000, 8'hA4, 8'hA4}; // d0 '2'
        vecs[12] = '{24'h000012, 6'b000000, 8'hF9, 8'hF9}; // d1 '1'
        vecs[13] = '{24'h000012, 6'b000000, 8'hC0, 8'hFF}; // d2 leading zero
        vecs[14] = '{24'h000012, 6'b001000, 8'h40, 8'h40}; // d3 zero with own dp
        vecs[15] = '{24'h070012, 6'b000000, 8'hF8, 8'hF8}; // d4 '7'
        vecs[16] = '{24'h070012, 6'b000000, 8'hC0, 8'hFF}; // d5 leading zero
        vecs[17] = '{24'h000000, 6'b000000, 8'hC0, 8'hC0}; // d0 never blanked
        vecs[18] = '{24'h000000, 6'b000000, 8'hC0, 8'hFF}; // d1 all zero
        vecs[19] = '{24'h000800, 6'b000000, 8'h80, 8'h80}; // d2 '8'
        vecs[20] = '{24'h000012, 6'b100000, 8'hC0, 8'hC0}; // d3 higher dp lit

        // Reset state.
        data      = 24'h123456;
        point     = 6'b000000;
        seg_en    = 1'b1;
        #3 sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("rst_ds",   {31'd0, ds},   32'd0);
        check("rst_shcp", {31'd0, shcp}, 32'd0);
        check("rst_stcp", {31'd0, stcp}, 32'd0);
        check("rst_oe",   {31'd0, oe},   32'd1);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check("oe_on", {31'd0, oe}, 32'd0);

        // First slot: digit 0 = '6' -> 14'b10000010_000001.
        frame_k = 0;
        check_frame("slot0", 8'h82);

        for (int i = 0; i < 21; i++) begin
            data  = vecs[i].data;
            point = vecs[i].point;
`ifdef SEG_LZ_BLANK_EN
            check_frame($sformatf("vec%0d", i), vecs[i].seg_lz);
`else
            check_frame($sformatf("vec%0d", i), vecs[i].seg_plain);
`endif
        end

        // Blank via oe while scanning continues.
        data   = 24'h500000;
        point  = 6'b000000;
        seg_en = 1'b0;
        #1 check("oe_lat_hold", {31'd0, oe}, 32'd0);
        @(negedge sys_clk);
        check("oe_off", {31'd0, oe}, 32'd1);
        check_frame("blanked_d4", 8'hC0);
        seg_en = 1'b1;
        #1 check("oe_off_hold", {31'd0, oe}, 32'd1);
        @(negedge sys_clk);
        check("oe_on_again", {31'd0, oe}, 32'd0);
        check_frame("enabled_d5", 8'h92);

        // Reset in the middle of a shift, just after the fifth shcp rise.
        hit = 1'b0;
        for (int n = 0; n < 200 && !hit; n++) begin
            @(negedge sys_clk);
            #1;
            if (mon_bits == 5) hit = 1'b1;
        end
        check("midshift_reached", {31'd0, hit}, 32'd1);
        #2 sys_rst_n = 1'b0;
        #1;
        check("mid_rst_ds",   {31'd0, ds},   32'd0);
        check("mid_rst_shcp", {31'd0, shcp}, 32'd0);
        check("mid_rst_stcp", {31'd0, stcp}, 32'd0);
        check("mid_rst_oe",   {31'd0, oe},   32'd1);
        frames.delete();
        data  = 24'h123456;
        point = 6'b000000;
        repeat (4) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        // Digit 0 again, on the first-slot schedule, with nothing latched earlier.
        frame_k = 0;
        check_frame("post_rst_slot0", 8'h82);
        check_frame("post_rst_slot1", 8'h92);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
